// File: rtl/leve_pkg.sv
// Shared types and widths for the LEVE instruction fetch unit.
// XLEN falls back to 64 when defs.vh has not already defined it.
`ifndef XLEN
`define XLEN 64
`endif

package leve_pkg;

    localparam int INST_W = 32;

    typedef struct packed {
        logic [`XLEN-1:0]  pc;
        logic [INST_W-1:0] inst;
        logic              done;
        logic              fault;
    } ifu_entry_t;

endpackage

// File: rtl/leve_pc_if.sv
// PC hand-off between the branch/PC generator (source) and the fetch unit (target).
`ifndef XLEN
`define XLEN 64
`endif

interface leve_pc_if;
    logic             VALID;
    logic [`XLEN-1:0] PC;
    logic             READY;

    modport target (input VALID, input PC, output READY);
    modport source (output VALID, output PC, input READY);
endinterface

// File: rtl/leve_ifu_chk.sv
// Protocol checker for the instruction-memory response channel of leve_ifu.
module leve_ifu_chk #(
    parameter int AW = 2
) (
    input logic        CLK,
    input logic        RST,
    input logic        IM_RVALID,
    input logic [AW:0] outstanding
);

    // A response with nothing owed means the memory side lost request ordering.
    a_rvalid_owed: assert property (@(posedge CLK) disable iff (RST)
        IM_RVALID |-> (outstanding != {(AW+1){1'b0}}));

endmodule

// File: rtl/leve_ifu_queue.sv
// In-order fetch queue: allocation (wp), fill (fp) and head (rp) pointers over DEPTH entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable by subtraction.
`ifndef XLEN
`define XLEN 64
`endif

module leve_ifu_queue
    import leve_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [`XLEN-1:0]  alloc_pc,
    input  logic              alloc_fault,
    input  logic              fill_en,
    input  logic [INST_W-1:0] fill_inst,
    input  logic              deq_en,
    output ifu_entry_t        head,
    output logic [AW:0]       alloc_cnt,
    output logic [AW:0]       unfilled_cnt
);

    ifu_entry_t  entry_r [DEPTH];
    logic [AW:0] wp_r;
    logic [AW:0] fp_r;
    logic [AW:0] rp_r;

    // Pointer update; a flush collapses head and fill onto the allocation pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_r <= {(AW+1){1'b0}};
            fp_r <= {(AW+1){1'b0}};
            rp_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wp_r <= wp_r;
            fp_r <= wp_r;
            rp_r <= wp_r;
        end else begin
            wp_r <= wp_r + (AW+1)'(alloc_en);
            fp_r <= fp_r + (AW+1)'(fill_en);
            rp_r <= rp_r + (AW+1)'(deq_en);
        end
    end

    // Entry storage: allocation records the PC, a fill records the word and marks it done.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '{pc: {`XLEN{1'b0}}, inst: {INST_W{1'b0}}, done: 1'b0, fault: 1'b0};
            end
        end else begin
            if (alloc_en && !flush) begin
                entry_r[wp_r[AW-1:0]].pc    <= alloc_pc;
                entry_r[wp_r[AW-1:0]].done  <= 1'b0;
                entry_r[wp_r[AW-1:0]].fault <= alloc_fault;
            end
            if (fill_en && !flush) begin
                entry_r[fp_r[AW-1:0]].inst <= fill_inst;
                entry_r[fp_r[AW-1:0]].done <= 1'b1;
            end
        end
    end

    assign head         = entry_r[rp_r[AW-1:0]];
    assign alloc_cnt    = wp_r - rp_r;
    assign unfilled_cnt = wp_r - fp_r;

endmodule

// File: rtl/leve_ifu.sv
// Instruction fetch unit: PC handshake, in-order memory reads, DEPTH-entry queue to decode.
// Optional LEVE_IFU_MISALIGN_EN adds per-entry fault tracking and the INST_FAULT port.
`ifndef XLEN
`define XLEN 64
`endif

module leve_ifu
    import leve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = `XLEN
) (
    input  logic              CLK,
    input  logic              RST,
    leve_pc_if.target         PC,
    output logic              IM_REQ,
    output logic [XLEN-1:0]   IM_ADDR,
    input  logic              IM_GNT,
    input  logic              IM_RVALID,
    input  logic [INST_W-1:0] IM_RDATA,
    input  logic              FLUSH,
    output logic              INST_VALID,
    output logic [INST_W-1:0] INST,
    output logic [XLEN-1:0]   INST_PC,
`ifdef LEVE_IFU_MISALIGN_EN
    output logic              INST_FAULT,
`endif
    input  logic              INST_READY
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW:0]   CNT_0   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_1   = {{AW{1'b0}}, 1'b1};

    ifu_entry_t  head_s;
    logic [AW:0] alloc_cnt_s;
    logic [AW:0] unfilled_cnt_s;
    logic [AW:0] outstanding_s;
    logic [AW:0] drop_r;
    logic        credit_s;
    logic        ready_s;
    logic        issue_s;
    logic        rsp_s;
    logic        fill_s;
    logic        deq_s;
    logic        fault_s;

    // Flushed-but-unreturned reads still occupy credit until their responses drain.
    assign credit_s      = ({1'b0, alloc_cnt_s} + {1'b0, drop_r}) < DEPTH_W;
    assign ready_s       = IM_GNT & credit_s & ~FLUSH & ~RST;
    assign PC.READY      = ready_s;
    assign IM_REQ        = PC.VALID & credit_s & ~FLUSH & ~RST;
    assign IM_ADDR       = {PC.PC[XLEN-1:2], 2'b00};
    assign issue_s       = PC.VALID & ready_s;

    assign outstanding_s = drop_r + unfilled_cnt_s;
    assign rsp_s         = IM_RVALID & (outstanding_s != CNT_0);
    assign fill_s        = IM_RVALID & (drop_r == CNT_0) & (unfilled_cnt_s != CNT_0) & ~FLUSH;
    assign deq_s         = INST_VALID & INST_READY & ~FLUSH;

    // Responses owed to flushed requests; a flush converts every unfilled entry into one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_r <= CNT_0;
        end else if (FLUSH) begin
            drop_r <= outstanding_s - (AW+1)'(rsp_s);
        end else if (IM_RVALID && (drop_r != CNT_0)) begin
            drop_r <= drop_r - CNT_1;
        end else begin
            drop_r <= drop_r;
        end
    end

`ifdef LEVE_IFU_MISALIGN_EN
    assign fault_s    = |PC.PC[1:0];
    assign INST_FAULT = head_s.fault;
`else
    logic unused_fault_s;
    assign fault_s        = 1'b0;
    assign unused_fault_s = head_s.fault;
`endif

    leve_ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK          (CLK),
        .RST          (RST),
        .flush        (FLUSH),
        .alloc_en     (issue_s),
        .alloc_pc     (PC.PC),
        .alloc_fault  (fault_s),
        .fill_en      (fill_s),
        .fill_inst    (IM_RDATA),
        .deq_en       (deq_s),
        .head         (head_s),
        .alloc_cnt    (alloc_cnt_s),
        .unfilled_cnt (unfilled_cnt_s)
    );

    leve_ifu_chk #(.AW(AW)) u_chk (
        .CLK         (CLK),
        .RST         (RST),
        .IM_RVALID   (IM_RVALID),
        .outstanding (outstanding_s)
    );

    assign INST_VALID = (alloc_cnt_s != CNT_0) & head_s.done;
    assign INST       = head_s.inst;
    assign INST_PC    = head_s.pc;

endmodule
